// File: rtl/key_conditioner_pkg.sv
// key_pkg: shared state encoding, default timing constants and width helper
package key_pkg;
  typedef enum logic [1:0] {KS_IDLE, KS_WAIT, KS_REPEAT} key_state_t;
  localparam int DEF_N_KEYS = 4;
  localparam int DEF_DEB_CYCLES = 16384;
  localparam int DEF_REPEAT_DELAY = 1500000;
  localparam int DEF_REPEAT_PERIOD = 300000;
  localparam logic [3:0] DEF_REPEAT_MASK = 4'b0011;
  function automatic int cw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw key pins in, conditioned key events out
interface key_conditioner_if #(parameter int N = 4);
  logic [N-1:0] i_key;
  logic [N-1:0] o_level;
  logic [N-1:0] o_press;
  logic [N-1:0] o_release;
  logic [N-1:0] o_hold;
  modport master(output i_key, input o_level, o_press, o_release, o_hold);
  modport slave(input i_key, output o_level, o_press, o_release, o_hold);
endinterface

// File: rtl/key_conditioner_channel.sv
// key_channel: one key's synchroniser, debounce counter and auto-repeat FSM
module key_channel
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);
  localparam int CW = cw(DEB_CYCLES);
  localparam int TW = cw(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic sync1, sync2, stable;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr, tmr_n;
  key_state_t st, st_n;
  logic press_n, rel_n, dp, dr;
  // stable has moved but o_level not yet: exactly one cycle per accepted edge
  assign dp = ~stable & ~o_level;
  assign dr = stable & o_level;
  assign o_hold = st == KS_REPEAT;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      stable <= 1'b1;
      cnt <= '0;
      o_level <= 1'b0;
      o_press <= 1'b0;
      o_release <= 1'b0;
      st <= KS_IDLE;
      tmr <= '0;
    end else begin
      sync1 <= i_key;
      sync2 <= sync1;
      if (sync2 == stable) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= sync2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
      o_level <= ~stable;
      o_press <= press_n;
      o_release <= rel_n;
      st <= st_n;
      tmr <= tmr_n;
    end
  end
  // a release takes priority over any timer expiry in the same cycle
  always_comb begin
    st_n = st;
    tmr_n = tmr;
    press_n = 1'b0;
    rel_n = dr;
    if (dr) begin
      st_n = KS_IDLE;
      tmr_n = '0;
    end else begin
      case (st)
        KS_IDLE: if (dp) begin
          press_n = 1'b1;
          st_n = REPEAT_EN ? KS_WAIT : KS_IDLE;
          tmr_n = '0;
        end
        KS_WAIT: if (tmr == TW'(REPEAT_DELAY - 1)) begin
          press_n = 1'b1;
          st_n = KS_REPEAT;
          tmr_n = '0;
        end else tmr_n = tmr + 1'b1;
        KS_REPEAT: if (tmr == TW'(REPEAT_PERIOD - 1)) begin
          press_n = 1'b1;
          tmr_n = '0;
        end else tmr_n = tmr + 1'b1;
        default: st_n = KS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: independent debounce/auto-repeat channels for the front-panel keys
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS = DEF_N_KEYS,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic [N_KEYS-1:0] REPEAT_MASK = N_KEYS'(DEF_REPEAT_MASK)
) (
  input logic i_clk,
  input logic i_rst_n,
  key_conditioner_if.slave kif
);
  logic [N_KEYS-1:0] level, press, rel, hold;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEB_CYCLES(DEB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN(REPEAT_MASK[i])
    ) u_ch (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_key(kif.i_key[i]),
      .o_level(level[i]),
      .o_press(press[i]),
      .o_release(rel[i]),
      .o_hold(hold[i])
    );
  end
  assign kif.o_level = level;
  assign kif.o_press = press;
  assign kif.o_release = rel;
  assign kif.o_hold = hold;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: random and directed key stimulus against an event-time reference model
module tb_key_conditioner;
  localparam int DEB = 4, RD = 10, RP = 3;
  localparam logic [3:0] MASK = 4'b0011;
  typedef struct {int t; logic [3:0] p; logic [3:0] r;} ev_t;
  logic clk = 0, rst_n = 0;
  int total = 0, bad = 0, t = 0;
  int pcnt[4];
  ev_t q[$];
  bit smp[4][$];
  bit stab[4], pr[4];
  int pt[4];
  logic [3:0] exp_level = 0, exp_hold = 0;
  key_conditioner_if #(.N(4)) kif();
  key_conditioner #(.N_KEYS(4), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_MASK(MASK)) dut (.i_clk(clk), .i_rst_n(rst_n), .kif(kif));
  always #5 clk = ~clk;
  task automatic chk(string n, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", n, a, e);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      smp[i].delete();
      repeat (DEB + 3) smp[i].push_back(1'b1);
      stab[i] = 1;
      pr[i] = 0;
      pt[i] = 0;
    end
    exp_level = 0;
    exp_hold = 0;
  endtask
  // reference: a level is accepted once DEB consecutive synchronised samples differ
  // from the current level; pulses follow at fixed offsets from the press time
  always @(posedge clk) begin
    t++;
    if (!rst_n) model_reset();
    else begin
      logic [3:0] p, r;
      p = 0;
      r = 0;
      for (int i = 0; i < 4; i++) begin
        bit v, ok;
        smp[i].push_back(kif.i_key[i]);
        void'(smp[i].pop_front());
        v = smp[i][$-3];
        ok = v != stab[i];
        for (int j = 3; j <= DEB + 2; j++) if (smp[i][$-j] != v) ok = 0;
        if (ok) begin
          stab[i] = v;
          if (!v) begin
            p[i] = 1;
            pr[i] = 1;
            pt[i] = t;
          end else begin
            r[i] = 1;
            pr[i] = 0;
          end
        end else if (pr[i] && MASK[i]) begin
          int d;
          d = t - pt[i];
          if (d == RD || (d > RD && (d - RD) % RP == 0)) p[i] = 1;
        end
        exp_level[i] = pr[i];
        exp_hold[i] = pr[i] && MASK[i] && (t - pt[i] >= RD);
      end
      if ((p | r) != 0) q.push_back('{t, p, r});
    end
  end
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) if (kif.o_press[i]) pcnt[i]++;
    if (rst_n) begin
      while (q.size() > 0 && q[0].t < t) begin
        total++;
        bad++;
        $display("FAIL missed_event t=%0d exp_press=%b exp_release=%b", q[0].t, q[0].p, q[0].r);
        void'(q.pop_front());
      end
      if ((kif.o_press | kif.o_release) != 0) begin
        total++;
        if (q.size() == 0 || q[0].t != t || q[0].p != kif.o_press || q[0].r != kif.o_release) begin
          bad++;
          $display("FAIL event t=%0d act_press=%b act_release=%b exp_t=%0d exp_press=%b exp_release=%b",
            t, kif.o_press, kif.o_release, q.size() ? q[0].t : -1, q.size() ? q[0].p : 4'b0,
            q.size() ? q[0].r : 4'b0);
        end
        if (q.size() > 0 && q[0].t == t) void'(q.pop_front());
      end
      total++;
      if (kif.o_level != exp_level || kif.o_hold != exp_hold) begin
        bad++;
        $display("FAIL level_hold t=%0d act=%b/%b exp=%b/%b", t, kif.o_level, kif.o_hold,
          exp_level, exp_hold);
      end
    end
  end
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int b0, b1, b2;
    kif.i_key = 4'hF;
    idle(3);
    chk("reset_outputs", {kif.o_level, kif.o_press, kif.o_release, kif.o_hold}, 0);
    rst_n = 1;
    idle(5);
    b0 = pcnt[3];
    kif.i_key[3] = 0;
    idle(40);
    kif.i_key[3] = 1;
    idle(20);
    chk("key3_single_press", pcnt[3] - b0, 1);
    b0 = pcnt[0];
    kif.i_key[0] = 0;
    idle(3);
    kif.i_key[0] = 1;
    idle(15);
    chk("glitch_no_press", pcnt[0] - b0, 0);
    b1 = pcnt[1];
    for (int k = 0; k < 10; k++) begin
      kif.i_key[1] = k[0];
      idle(2);
    end
    kif.i_key[1] = 0;
    idle(12);
    chk("bounce_one_press", pcnt[1] - b1, 1);
    kif.i_key[1] = 1;
    idle(20);
    b0 = pcnt[0];
    kif.i_key[0] = 0;
    idle(40);
    kif.i_key[0] = 1;
    idle(20);
    chk("repeat_count", pcnt[0] - b0, 11);
    b1 = pcnt[1];
    b2 = pcnt[2];
    kif.i_key[2:1] = 2'b00;
    idle(30);
    kif.i_key[2:1] = 2'b11;
    idle(20);
    chk("simul_key1_repeats", pcnt[1] - b1, 8);
    chk("simul_key2_once", pcnt[2] - b2, 1);
    kif.i_key[0] = 0;
    idle(30);
    chk("hold_before_reset", int'(kif.o_hold[0]), 1);
    rst_n = 0;
    #1;
    chk("reset_mid_repeat", {kif.o_level, kif.o_press, kif.o_release, kif.o_hold}, 0);
    idle(2);
    b0 = pcnt[0];
    rst_n = 1;
    idle(15);
    chk("post_reset_press", pcnt[0] - b0, 1);
    idle(4);
    chk("post_reset_repeat", pcnt[0] - b0, 2);
    kif.i_key[0] = 1;
    idle(20);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) kif.i_key[i] = ~kif.i_key[i];
      if ($urandom_range(0, 199) == 0) idle($urandom_range(20, 60));
    end
    kif.i_key = 4'hF;
    idle(30);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the four raw, active-low push-buttons before they reach the menu/control core (select/back/up/down inputs).
- Per key: 2-FF synchroniser, counter-based debounce, single-cycle press and release pulses.
- Optional auto-repeat on long hold, so up/down can sweep band gain without repeated pressing.
- Runs entirely in the audio bit-clock domain; outputs are synchronous, single-cycle pulses the control core consumes directly.

Parameters:
N_KEYS, 4, number of independent key channels
DEB_CYCLES, 16384, consecutive cycles a new synchronised level must hold before it is accepted (>=2)
REPEAT_DELAY, 1500000, cycles a key must stay pressed after its press pulse before the first repeat pulse (>=1)
REPEAT_PERIOD, 300000, cycles between successive repeat pulses (>=1)
REPEAT_MASK, 4'b0011, bit i=1 enables auto-repeat on key i (default: up/down only)

Ports:
i_clk  input  1  audio bit clock; all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_key  input  N_KEYS  raw key pins, 0 = pressed, asynchronous to i_clk
o_level  output  N_KEYS  debounced level, 1 = pressed
o_press  output  N_KEYS  one-cycle pulse on accepted press and on each auto-repeat
o_release  output  N_KEYS  one-cycle pulse on accepted release
o_hold  output  N_KEYS  high while key i is in auto-repeat

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - Sync flops and stable level are set to 1 (released).
  - Debounce and repeat counters are cleared to 0.
  - FSM is set to KS_IDLE.
  - o_level, o_press, o_release and o_hold are all 0.
  - Asserting reset mid-hold or mid-debounce drops everything immediately.
  - After release of reset, a key held throughout produces a normal press event after debounce.
- Channels are fully independent; simultaneous events on several keys all appear in the same cycle, with no priority or lockout.
- Synchroniser: sync1 <= i_key[i]; sync2 <= sync1.
- Debounce:
  - sync2 == stable: cnt <= 0.
  - Otherwise, if cnt == DEB_CYCLES-1: stable <= sync2 and cnt <= 0; else cnt <= cnt+1.
  - Counter width is $clog2(DEB_CYCLES).
  - Any return to the stable level before acceptance clears cnt, so a glitch shorter than DEB_CYCLES produces no event.
- Latency: if a raw edge is first sampled on edge k, stable changes on edge k+DEB_CYCLES+1. o_press or o_release rises on edge k+DEB_CYCLES+2 and lasts exactly one cycle.
- o_level = registered ~stable, updated on the same edge as the pulse.
- Repeat FSM per key (timer width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD))):
  - KS_IDLE:
    - Debounced press: emit o_press.
    - If REPEAT_MASK[i] is set, go to KS_WAIT with timer 0; otherwise stay in KS_IDLE.
  - KS_WAIT:
    - Timer increments each cycle.
    - When timer == REPEAT_DELAY-1: emit o_press, go to KS_REPEAT, timer 0.
  - KS_REPEAT:
    - o_hold = 1.
    - When timer == REPEAT_PERIOD-1: emit o_press, timer 0.
  - Debounced release in any state:
    - Emit o_release, go to KS_IDLE, timer 0, o_hold 0 on the next edge.
    - No o_press is issued in that cycle even if the timer expires simultaneously; release wins.
- o_press and o_release for the same key are never high in the same cycle.

Decomposition:
- Package key_pkg holds:
  - typedef enum logic[1:0] key_state_t {KS_IDLE, KS_WAIT, KS_REPEAT};
  - localparam default timing constants;
  - helper function for counter widths.
- Sub-module key_channel: one key, containing sync, debounce and repeat FSM, with scalar ports.
- key_conditioner is a generate loop over N_KEYS instances, passing REPEAT_MASK[i] as a per-instance enable parameter.

Test Plan:
(All tests use DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=4'b0011.)
- Clean press on key3 sampled at edge 20, held 40 cycles:
  - o_press[3] high for exactly one cycle after edge 26; o_level[3]=1 from edge 26.
  - No repeat pulses.
  - Release: o_release[3] one cycle, 6 edges after the release is sampled.
- Glitch: key0 low for 3 cycles then high -> no o_press, o_release or o_level change; cnt returns to 0.
- Bounce: key1 toggles every 2 cycles for 20 cycles, then stays low -> exactly one o_press, 6 edges after the final falling sample.
- Auto-repeat on key0, held 40 cycles past its press pulse:
  - First repeat pulse 10 cycles after the initial press pulse, then every 3 cycles: 11 press pulses in total.
  - o_hold[0] high from the first repeat pulse until release.
- Simultaneous: keys 1 and 2 pressed on the same edge -> o_press=4'b0110 in a single cycle; only key1 later repeats.
- Reset mid-repeat: drop i_rst_n while key0 is in KS_REPEAT -> all outputs 0 immediately. Release reset with the key still held -> a fresh press pulse 6 edges after the first post-reset sample, then the full REPEAT_DELAY before any repeat.
